// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg
//   Shared definitions for the memory-stage access unit: access size
//   encodings, FSM state type, byte-enable width and the alignment rule.
package mem_access_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;  // 2'b11 is also treated as a word

  localparam int BYTE_EN_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_DONE     = 2'd3
  } mau_state_e;

  // Byte accesses are always aligned; halves need addr[0]=0; words need addr[1:0]=0.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~addr_lo[0];
      default: ok = (addr_lo == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// load_align_unit
//   Combinational load lane select and extension.
//   addr_lo     : byte offset of the access within the word
//   size        : SZ_BYTE / SZ_HALF / word
//   is_unsigned : 1 = zero-extend, 0 = sign-extend
//   rdata       : raw word returned by data memory
//   data        : lane-selected, extended load value
module load_align_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            addr_lo,
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] shifted;
  logic                  fill;

  always_comb begin
    // Move the addressed lane down to bit 0.
    shifted = rdata >> {addr_lo, 3'b000};
    fill    = 1'b0;
    data    = rdata;
    case (size)
      SZ_BYTE: begin
        fill = ~is_unsigned & shifted[7];
        data = {{(DATA_WIDTH-8){fill}}, shifted[7:0]};
      end
      SZ_HALF: begin
        fill = ~is_unsigned & shifted[15];
        data = {{(DATA_WIDTH-16){fill}}, shifted[15:0]};
      end
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Memory stage between EX/MEM and MEM/WB. Issues one valid/ready request
//   per aligned load/store, aligns and byte-enables stores, extends load
//   data, stalls the upstream pipeline while an access is outstanding and
//   shows a bubble to MEM/WB until the access completes.
//
//   Handshake: a request transfers on a rising clock edge where
//   dmem_req_valid && dmem_req_ready. While valid is high and ready is low,
//   write/addr/wdata/byte_en stay stable (the stall freezes EX/MEM).
//   dmem_rsp_valid is honoured only in ST_WAIT_RSP.
//
//   Ports:
//     clock, reset (async, active-low)
//     mem_*          : stage control/data from EX/MEM
//     dmem_*         : data-memory request/response port
//     mem_stall      : freezes PC, IF/ID, ID/EX, EX/MEM
//     out_*          : toward MEM/WB
//     mem_misaligned : one-cycle pulse for a misaligned access
//     wait_cycles    : saturating count of stalled cycles
//     dbg_state      : current FSM state
//     dbg_core       : core index, for tracing
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    mem_regWrite,
  input  logic                    mem_memRead,
  input  logic                    mem_memWrite,
  input  logic [1:0]              mem_size,
  input  logic                    mem_unsigned,
  input  logic [4:0]              mem_rd,
  input  logic [DATA_WIDTH-1:0]   mem_ALU_result,
  input  logic [DATA_WIDTH-1:0]   mem_store_data,
  output logic                    dmem_req_valid,
  input  logic                    dmem_req_ready,
  output logic                    dmem_req_write,
  output logic [ADDRESS_BITS-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0]   dmem_wdata,
  output logic [BYTE_EN_W-1:0]    dmem_byte_en,
  input  logic                    dmem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   dmem_rdata,
  output logic                    mem_stall,
  output logic                    out_regWrite,
  output logic                    out_memRead,
  output logic [4:0]              out_rd,
  output logic [DATA_WIDTH-1:0]   out_ALU_result,
  output logic [DATA_WIDTH-1:0]   out_memory_data,
  output logic                    mem_misaligned,
  output logic [31:0]             wait_cycles,
  output logic [1:0]              dbg_state,
  output logic [31:0]             dbg_core
);

  mau_state_e            state, state_next;
  logic [1:0]            addr_lo;
  logic                  is_mem_op, is_load, aligned, access_present, misaligned;
  logic [DATA_WIDTH-1:0] load_q, load_ext;

  assign addr_lo        = mem_ALU_result[1:0];
  assign is_mem_op      = mem_memRead | mem_memWrite;
  // Read wins when both read and write are set.
  assign is_load        = mem_memRead;
  assign aligned        = is_aligned(mem_size, addr_lo);
  assign access_present = is_mem_op & aligned;
  assign misaligned     = is_mem_op & ~aligned;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state and handshake/stall outputs. Outputs are gated by reset so
  // nothing leaks out while reset is held, even if an access is presented.
  always_comb begin
    state_next     = state;
    dmem_req_valid = 1'b0;
    mem_stall      = 1'b0;
    case (state)
      ST_IDLE: begin
        mem_stall = access_present;
        if (access_present) state_next = ST_REQ;
      end
      ST_REQ: begin
        dmem_req_valid = 1'b1;
        // A store finishes in its acceptance cycle, so the stall drops there.
        mem_stall      = is_load | ~dmem_req_ready;
        if (dmem_req_ready) state_next = is_load ? ST_WAIT_RSP : ST_IDLE;
      end
      ST_WAIT_RSP: begin
        mem_stall = 1'b1;
        if (dmem_rsp_valid) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    mem_stall      = mem_stall & reset;
    dmem_req_valid = dmem_req_valid & reset;
  end

  // Store lane placement
  always_comb begin
    dmem_byte_en = 4'b1111;
    dmem_wdata   = mem_store_data;
    case (mem_size)
      SZ_BYTE: begin
        dmem_byte_en = 4'b0001 << addr_lo;
        dmem_wdata   = {(DATA_WIDTH/8){mem_store_data[7:0]}};
      end
      SZ_HALF: begin
        dmem_byte_en = 4'b0011 << addr_lo;
        dmem_wdata   = {(DATA_WIDTH/16){mem_store_data[15:0]}};
      end
      default: begin
        dmem_byte_en = 4'b1111;
        dmem_wdata   = mem_store_data;
      end
    endcase
  end

  assign dmem_req_write = mem_memWrite & ~mem_memRead;
  assign dmem_addr      = mem_ALU_result[ADDRESS_BITS+1:2];

  load_align_unit #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_align (
    .addr_lo    (addr_lo),
    .size       (mem_size),
    .is_unsigned(mem_unsigned),
    .rdata      (dmem_rdata),
    .data       (load_ext)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      load_q <= '0;
    end else if (state == ST_WAIT_RSP && dmem_rsp_valid) begin
      load_q <= load_ext;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cycles <= '0;
    end else if (mem_stall && wait_cycles != 32'hFFFF_FFFF) begin
      wait_cycles <= wait_cycles + 32'd1;
    end
  end

  // Misaligned ops never leave IDLE, so the pulse lasts the single cycle
  // the op sits in the stage.
  assign mem_misaligned  = reset & misaligned & (state == ST_IDLE);
  assign out_regWrite    = reset & mem_regWrite & ~mem_stall & ~misaligned;
  assign out_memRead     = mem_memRead;
  assign out_rd          = mem_rd;
  assign out_ALU_result  = mem_ALU_result;
  assign out_memory_data = (state == ST_DONE) ? load_q : '0;

  assign dbg_state = state;
  assign dbg_core  = 32'(CORE);

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        mem_regWrite, mem_memRead, mem_memWrite, mem_unsigned;
  logic [1:0]  mem_size;
  logic [4:0]  mem_rd;
  logic [31:0] mem_ALU_result, mem_store_data;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_write;
  logic [19:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_byte_en;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rdata;
  logic        mem_stall, out_regWrite, out_memRead, mem_misaligned;
  logic [4:0]  out_rd;
  logic [31:0] out_ALU_result, out_memory_data, wait_cycles, dbg_core;
  logic [1:0]  dbg_state;

  mem_access_unit #(.CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(20)) dut (
    .clock(clock), .reset(reset),
    .mem_regWrite(mem_regWrite), .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .mem_rd(mem_rd),
    .mem_ALU_result(mem_ALU_result), .mem_store_data(mem_store_data),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_write(dmem_req_write), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_byte_en(dmem_byte_en), .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .out_regWrite(out_regWrite), .out_memRead(out_memRead),
    .out_rd(out_rd), .out_ALU_result(out_ALU_result), .out_memory_data(out_memory_data),
    .mem_misaligned(mem_misaligned), .wait_cycles(wait_cycles),
    .dbg_state(dbg_state), .dbg_core(dbg_core)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_wait = 0;

  typedef struct packed {
    int          stalls;
    int          req_cycles;
    int          mis;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [19:0] addr;
    logic        wr;
    logic        stable;
    logic        regw;
    logic        memr;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] mdata;
    logic        timeout;
  } obs_t;

  // ---------------- reference model ----------------
  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit model_aligned(input logic [31:0] a, input logic [1:0] sz);
    return (a % size_bytes(sz)) == 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                             input logic uns, input logic [31:0] rdata);
    int nb, off;
    longint unsigned v;
    nb  = size_bytes(sz);
    off = a % 4;
    v   = longint'(rdata) >> (8 * off);
    v   = v & ((64'd1 << (8 * nb)) - 1);
    if (!uns && nb < 4 && ((v >> (8 * nb - 1)) & 1) == 1)
      v = v + (64'd1 << 32) - (64'd1 << (8 * nb));
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_be(input logic [31:0] a, input logic [1:0] sz);
    int nb;
    nb = size_bytes(sz);
    if (nb == 4) return 4'hF;
    return 4'(((1 << nb) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] sd, input logic [1:0] sz);
    int nb;
    longint unsigned low, v;
    nb  = size_bytes(sz);
    low = longint'(sd) & ((64'd1 << (8 * nb)) - 1);
    v   = 0;
    for (int i = 0; i < 4; i += nb) v = v | (low << (8 * i));
    return v[31:0];
  endfunction

  // ---------------- driver ----------------
  task automatic set_nop();
    mem_regWrite = 0; mem_memRead = 0; mem_memWrite = 0; mem_unsigned = 0;
    mem_size = 2'b10; mem_rd = 0; mem_ALU_result = 0; mem_store_data = 0;
  endtask

  // Presents one op, plays the memory side, and records what the DUT showed
  // up to and including the first cycle without a stall (the op leaves then).
  task automatic do_access(input logic rw, input logic mr, input logic mw,
                           input logic [1:0] sz, input logic un, input logic [4:0] rd,
                           input logic [31:0] alu, input logic [31:0] sd,
                           input logic [31:0] rdv, input int req_wait, input int rsp_wait,
                           output obs_t o);
    bit pending, first, done, fire, rsp_fire;
    int cnt;
    o = '0;
    o.stable = 1'b1;
    pending = 0; first = 1; done = 0; cnt = 0;
    @(negedge clock);
    mem_regWrite = rw; mem_memRead = mr; mem_memWrite = mw; mem_size = sz;
    mem_unsigned = un; mem_rd = rd; mem_ALU_result = alu; mem_store_data = sd;
    dmem_req_ready = 0; dmem_rsp_valid = 0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (cyc > 0) @(negedge clock);
      if (dmem_req_valid) begin
        o.req_cycles++;
        dmem_req_ready = (o.req_cycles > req_wait);
        if (first) begin
          o.be = dmem_byte_en; o.wdata = dmem_wdata; o.addr = dmem_addr; o.wr = dmem_req_write;
          first = 0;
        end else if (dmem_byte_en !== o.be || dmem_wdata !== o.wdata ||
                     dmem_addr !== o.addr || dmem_req_write !== o.wr) begin
          o.stable = 1'b0;
        end
      end else begin
        dmem_req_ready = 0;
      end
      if (pending && cnt == rsp_wait) begin
        dmem_rsp_valid = 1; dmem_rdata = rdv;
      end else begin
        dmem_rsp_valid = 0; dmem_rdata = $urandom;
      end
      #1;
      if (mem_stall === 1'b1) o.stalls++;
      if (mem_misaligned === 1'b1) o.mis++;
      if (mem_stall === 1'b0) begin
        o.regw = out_regWrite; o.memr = out_memRead; o.rd = out_rd;
        o.alu = out_ALU_result; o.mdata = out_memory_data;
        done = 1;
      end
      fire     = dmem_req_valid && dmem_req_ready && !dmem_req_write;
      rsp_fire = dmem_rsp_valid;
      @(posedge clock);
      if (rsp_fire) pending = 0;
      else if (pending) cnt++;
      if (fire) begin pending = 1; cnt = 0; end
    end
    if (!done) o.timeout = 1'b1;
    #1;
    dmem_req_ready = 0; dmem_rsp_valid = 0;
    set_nop();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_nop();
    mem_regWrite = 1; mem_memRead = 1; mem_ALU_result = 32'h10;
    dmem_req_ready = 1; dmem_rsp_valid = 0; dmem_rdata = 0;
    reset = 0;
    repeat (2) @(negedge clock);
    #1;
    checks++; if (dmem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b expected 0", dmem_req_valid); end
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b expected 0", mem_stall); end
    checks++; if (out_regWrite !== 1'b0) begin errors++; $display("FAIL rst_regwrite: got %b expected 0", out_regWrite); end
    checks++; if (wait_cycles !== 32'd0) begin errors++; $display("FAIL rst_wait: got %0d expected 0", wait_cycles); end
    checks++; if (out_memory_data !== 32'd0) begin errors++; $display("FAIL rst_mdata: got %h expected 0", out_memory_data); end
    @(negedge clock);
    set_nop();
    dmem_req_ready = 0;
    reset = 1;
    exp_wait = 0;
    @(negedge clock); #1;
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    checks++; if (wait_cycles !== exp_wait) begin errors++; $display("FAIL rst_wait_after: got %0d expected %0d", wait_cycles, exp_wait); end
  endtask

  task automatic test_load_word();
    obs_t o;
    do_access(1, 1, 0, 2'b10, 0, 5'd7, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0, o);
    exp_wait += 3;
    checks++; if (o.timeout) begin errors++; $display("FAIL lw_timeout: got 1 expected 0"); end
    checks++; if (o.stalls !== 3) begin errors++; $display("FAIL lw_stalls: got %0d expected 3", o.stalls); end
    checks++; if (o.mdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h expected deadbeef", o.mdata); end
    checks++; if (o.regw !== 1'b1) begin errors++; $display("FAIL lw_regwrite: got %b expected 1", o.regw); end
    checks++; if (o.addr !== 20'h4) begin errors++; $display("FAIL lw_addr: got %h expected 4", o.addr); end
    checks++; if (o.wr !== 1'b0) begin errors++; $display("FAIL lw_write: got %b expected 0", o.wr); end
    checks++; if (wait_cycles !== exp_wait) begin errors++; $display("FAIL lw_wait: got %0d expected %0d", wait_cycles, exp_wait); end
  endtask

  task automatic test_load_extend();
    obs_t o;
    do_access(1, 1, 0, 2'b00, 0, 5'd3, 32'h13, 32'h0, 32'h80000000, 0, 0, o);
    exp_wait += 3;
    checks++; if (o.mdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_sext: got %h expected ffffff80", o.mdata); end
    do_access(1, 1, 0, 2'b01, 1, 5'd4, 32'h12, 32'h0, 32'h80010000, 1, 2, o);
    exp_wait += 6;
    checks++; if (o.mdata !== 32'h00008001) begin errors++; $display("FAIL lhu_zext: got %h expected 00008001", o.mdata); end
    checks++; if (o.stalls !== 6) begin errors++; $display("FAIL lhu_stalls: got %0d expected 6", o.stalls); end
  endtask

  task automatic test_store_backpressure();
    obs_t o;
    do_access(0, 0, 1, 2'b00, 0, 5'd0, 32'h21, 32'h000000AB, 32'h0, 4, 0, o);
    exp_wait += 5;
    checks++; if (o.be !== 4'b0010) begin errors++; $display("FAIL sb_be: got %b expected 0010", o.be); end
    checks++; if (o.wdata !== 32'hABABABAB) begin errors++; $display("FAIL sb_wdata: got %h expected abababab", o.wdata); end
    checks++; if (o.stable !== 1'b1) begin errors++; $display("FAIL sb_stable: got %b expected 1", o.stable); end
    checks++; if (o.req_cycles !== 5) begin errors++; $display("FAIL sb_req_cycles: got %0d expected 5", o.req_cycles); end
    checks++; if (o.wr !== 1'b1) begin errors++; $display("FAIL sb_write: got %b expected 1", o.wr); end
    checks++; if (wait_cycles !== exp_wait) begin errors++; $display("FAIL sb_wait: got %0d expected %0d", wait_cycles, exp_wait); end
  endtask

  task automatic test_misaligned();
    obs_t o;
    do_access(1, 1, 0, 2'b10, 0, 5'd9, 32'h02, 32'h0, 32'h0, 0, 0, o);
    checks++; if (o.mis !== 1) begin errors++; $display("FAIL mis_pulse: got %0d expected 1", o.mis); end
    checks++; if (o.req_cycles !== 0) begin errors++; $display("FAIL mis_req: got %0d expected 0", o.req_cycles); end
    checks++; if (o.stalls !== 0) begin errors++; $display("FAIL mis_stall: got %0d expected 0", o.stalls); end
    checks++; if (o.regw !== 1'b0) begin errors++; $display("FAIL mis_regwrite: got %b expected 0", o.regw); end
    checks++; if (wait_cycles !== exp_wait) begin errors++; $display("FAIL mis_wait: got %0d expected %0d", wait_cycles, exp_wait); end
  endtask

  task automatic test_alu_passthrough();
    obs_t o;
    do_access(1, 0, 0, 2'b10, 0, 5'd21, 32'h1234_5677, 32'h0, 32'h0, 0, 0, o);
    checks++; if (o.stalls !== 0) begin errors++; $display("FAIL alu_stall: got %0d expected 0", o.stalls); end
    checks++; if (o.regw !== 1'b1) begin errors++; $display("FAIL alu_regwrite: got %b expected 1", o.regw); end
    checks++; if (o.rd !== 5'd21) begin errors++; $display("FAIL alu_rd: got %0d expected 21", o.rd); end
    checks++; if (o.alu !== 32'h1234_5677) begin errors++; $display("FAIL alu_result: got %h expected 12345677", o.alu); end
  endtask

  task automatic test_reset_mid_access();
    // Reset while a store request waits for ready: the request must vanish at once.
    @(negedge clock);
    mem_memWrite = 1; mem_size = 2'b10; mem_ALU_result = 32'h40; mem_store_data = 32'h5555_AAAA;
    dmem_req_ready = 0;
    @(negedge clock); #1;
    checks++; if (dmem_req_valid !== 1'b1) begin errors++; $display("FAIL mid_req_pending: got %b expected 1", dmem_req_valid); end
    reset = 0; #1;
    checks++; if (dmem_req_valid !== 1'b0) begin errors++; $display("FAIL mid_req_drop: got %b expected 0", dmem_req_valid); end
    set_nop();
    @(negedge clock); reset = 1;
    // Reset while a load waits for its response; the late response is ignored.
    @(negedge clock);
    mem_regWrite = 1; mem_memRead = 1; mem_size = 2'b10; mem_ALU_result = 32'h44;
    dmem_req_ready = 1;
    repeat (2) @(negedge clock);
    #1;
    checks++; if (dbg_state !== ST_WAIT_RSP) begin errors++; $display("FAIL mid_in_wait: got %0d expected %0d", dbg_state, ST_WAIT_RSP); end
    reset = 0; set_nop(); dmem_req_ready = 0; #1;
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL mid_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL mid_stall: got %b expected 0", mem_stall); end
    checks++; if (wait_cycles !== 32'd0) begin errors++; $display("FAIL mid_wait: got %0d expected 0", wait_cycles); end
    @(negedge clock); reset = 1;
    @(negedge clock); dmem_rsp_valid = 1; dmem_rdata = 32'hCAFEF00D;
    @(negedge clock); dmem_rsp_valid = 0; #1;
    exp_wait = 0;
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL stale_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    checks++; if (out_memory_data !== 32'd0) begin errors++; $display("FAIL stale_mdata: got %h expected 0", out_memory_data); end
    checks++; if (out_regWrite !== 1'b0) begin errors++; $display("FAIL stale_regwrite: got %b expected 0", out_regWrite); end
    checks++; if (wait_cycles !== exp_wait) begin errors++; $display("FAIL stale_wait: got %0d expected %0d", wait_cycles, exp_wait); end
  endtask

  task automatic test_random();
    obs_t o;
    logic rw, mr, mw, un;
    logic [1:0] sz;
    logic [4:0] rd;
    logic [31:0] alu, sd, rdv, exp_d;
    int kind, rq, rs, exp_stalls;
    bit mem, al, present;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 4);
      rw = (kind == 0 || kind == 1 || kind == 3) ? 1'b1 : 1'($urandom_range(0, 1));
      mr = (kind == 1 || kind == 3);
      mw = (kind == 2 || kind == 3);
      sz = 2'($urandom_range(0, 3));
      un = 1'($urandom_range(0, 1));
      rd = 5'($urandom);
      alu = $urandom;
      if ($urandom_range(0, 3) != 0) alu = alu - (alu % size_bytes(sz));
      sd = $urandom; rdv = $urandom;
      rq = $urandom_range(0, 3); rs = $urandom_range(0, 3);
      mem = mr | mw;
      al = model_aligned(alu, sz);
      present = mem && al;
      exp_stalls = !present ? 0 : (mr ? 3 + rq + rs : 1 + rq);
      exp_q.push_back((present && mr) ? model_load(alu, sz, un, rdv) : 32'd0);
      do_access(rw, mr, mw, sz, un, rd, alu, sd, rdv, rq, rs, o);
      exp_wait += exp_stalls;
      exp_d = exp_q.pop_front();
      checks++; if (o.timeout) begin errors++; $display("FAIL rnd%0d_timeout: got 1 expected 0", i); end
      checks++; if (o.stalls !== exp_stalls) begin errors++; $display("FAIL rnd%0d_stalls: got %0d expected %0d", i, o.stalls, exp_stalls); end
      checks++; if (o.mis !== ((mem && !al) ? 1 : 0)) begin errors++; $display("FAIL rnd%0d_mis: got %0d expected %0d", i, o.mis, (mem && !al) ? 1 : 0); end
      checks++; if (o.req_cycles !== (present ? rq + 1 : 0)) begin errors++; $display("FAIL rnd%0d_req: got %0d expected %0d", i, o.req_cycles, present ? rq + 1 : 0); end
      checks++; if (o.regw !== (rw && !(mem && !al))) begin errors++; $display("FAIL rnd%0d_regw: got %b expected %b", i, o.regw, rw && !(mem && !al)); end
      checks++; if (o.mdata !== exp_d) begin errors++; $display("FAIL rnd%0d_mdata: got %h expected %h", i, o.mdata, exp_d); end
      checks++; if (o.rd !== rd || o.alu !== alu || o.memr !== mr) begin errors++; $display("FAIL rnd%0d_pass: got rd=%0d alu=%h mr=%b expected rd=%0d alu=%h mr=%b", i, o.rd, o.alu, o.memr, rd, alu, mr); end
      if (present) begin
        checks++; if (o.addr !== alu[21:2] || o.wr !== (mw && !mr) || o.stable !== 1'b1) begin errors++; $display("FAIL rnd%0d_req_fields: got addr=%h wr=%b stable=%b expected addr=%h wr=%b stable=1", i, o.addr, o.wr, o.stable, alu[21:2], mw && !mr); end
      end
      if (present && !mr) begin
        checks++; if (o.be !== model_be(alu, sz) || o.wdata !== model_wdata(sd, sz)) begin errors++; $display("FAIL rnd%0d_store: got be=%b wdata=%h expected be=%b wdata=%h", i, o.be, o.wdata, model_be(alu, sz), model_wdata(sd, sz)); end
      end
      checks++; if (wait_cycles !== exp_wait) begin errors++; $display("FAIL rnd%0d_wait: got %0d expected %0d", i, wait_cycles, exp_wait); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    set_nop();
    dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rdata = 0;
    test_reset();
    test_load_word();
    test_load_extend();
    test_store_backpressure();
    test_misaligned();
    test_alu_passthrough();
    test_reset_mid_access();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access unit between the EX/MEM pipeline register and the MEM/WB pipeline register. Turns the stage's load/store control into a valid/ready request on the data-memory port. Aligns and byte-enables stores, and sign- or zero-extends load data. Stalls the upstream pipeline while an access is outstanding and presents a bubble (regWrite=0) to MEM/WB until the access completes.

## Interface
- CORE, 0, core index (carried for tracing only)
- DATA_WIDTH, 32, datapath width; lane logic is defined for 32 only
- ADDRESS_BITS, 20, word-address width of the data-memory port
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- mem_regWrite, mem_memRead, mem_memWrite  in  1 each  stage control from EX/MEM
- mem_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
- mem_unsigned  in  1  zero-extend loads when 1
- mem_rd  in  5  destination register
- mem_ALU_result  in  DATA_WIDTH  byte address / ALU result
- mem_store_data  in  DATA_WIDTH  unaligned store operand
- dmem_req_valid  out  1;  dmem_req_ready  in  1
- dmem_req_write  out  1;  dmem_addr  out  ADDRESS_BITS  = mem_ALU_result[ADDRESS_BITS+1:2]
- dmem_wdata  out  DATA_WIDTH;  dmem_byte_en  out  4
- dmem_rsp_valid  in  1;  dmem_rdata  in  DATA_WIDTH  (load responses only)
- mem_stall  out  1  freezes PC, IF/ID, ID/EX, EX/MEM
- out_regWrite, out_memRead  out  1;  out_rd  out  5;  out_ALU_result, out_memory_data  out  DATA_WIDTH  to MEM/WB
- mem_misaligned  out  1  one-cycle pulse on misaligned access
- wait_cycles  out  32  saturating count of cycles with mem_stall=1

## Operation
- Access present = (mem_memRead | mem_memWrite) & aligned. Aligned: byte always; half needs addr[0]=0; word needs addr[1:0]=0.
- If mem_memRead and mem_memWrite are both 1, treat as a load.
- FSM states:
  - IDLE → REQ when an access is present.
  - REQ: dmem_req_valid=1.
    - Load accepted (ready=1) → WAIT_RSP.
    - Store accepted → IDLE.
  - WAIT_RSP: on rsp_valid, capture extended data into load_q → DONE.
  - DONE → IDLE unconditionally.
- Store lanes: byte_en = 0001<<addr[1:0] (byte), 0011<<addr[1:0] (half), 1111 (word). wdata = byte/half replicated across lanes.
- Load extract: select lane by addr[1:0], then sign-extend from bit 7/15 (or zero-extend when mem_unsigned=1).
- mem_stall = (IDLE & access present) | REQ | WAIT_RSP. Store completes in the acceptance cycle, so stall drops in the REQ cycle where ready=1.
- out_regWrite = mem_regWrite & ~mem_stall & ~misaligned. out_rd, out_ALU_result, out_memRead pass through.
- out_memory_data = load_q in DONE, else 0.
- Misaligned access: no request issued, mem_misaligned=1 for the cycle the op is presented, no stall, out_regWrite=0.
- Non-memory ops pass through combinationally with zero stall.
- wait_cycles increments each mem_stall cycle and saturates at 0xFFFF_FFFF.

## Timing
- Reset (async assert, sync deassert by the clock tree): FSM=IDLE, load_q=0, wait_cycles=0. dmem_req_valid=0, mem_stall=0, out_regWrite=0 while reset=0.
- Store, ready=1 at first REQ: 1 stall cycle (IDLE detect), request in cycle T+1.
- Load, ready and rsp with zero wait: T IDLE (stall) → T+1 REQ → T+2 WAIT_RSP, rsp captured → T+3 DONE, out_regWrite=1, MEM/WB captures at the end of T+3. Minimum 3 stall cycles.
- dmem_req_valid, write, addr, wdata and byte_en are held stable while ready=0.
- rsp_valid is ignored outside WAIT_RSP, including stale responses after a mid-access reset.
- Reset mid-access: FSM returns to IDLE immediately, and the request is dropped without waiting for ready.

## Structure
- Shared package: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state enum, byte-enable width constant.
- One sub-module, load_align_unit: combinational lane select and extension (addr[1:0], size, unsigned, rdata → data).

## Test plan
- lw to 0x10, rdata=0xDEADBEEF, ready and rsp with 0 wait → stall for 3 cycles; out_memory_data=0xDEADBEEF with out_regWrite=1 in DONE.
- lb unsigned=0 to 0x13, rdata=0x80000000 → 0xFFFFFF80. lhu to 0x12, rdata=0x80010000 → 0x00008001.
- sb 0xAB to 0x21 with ready held low 4 cycles → byte_en=0010, wdata=0xABABABAB stable throughout; wait_cycles advances by 5.
- lw to 0x02 → mem_misaligned pulse, no dmem_req_valid, out_regWrite=0, no stall.
- reset=0 asserted in WAIT_RSP, then rsp_valid after release → FSM IDLE, response ignored, outputs at reset values.
- ALU op (regWrite=1, no mem) → pass-through same cycle, mem_stall=0.
